// File: rtl/i2s_tx.sv
// I2S transmitter: accepts stereo sample pairs over valid/ready, serializes them
// left-first, MSB-first with a one-bclk delay bit, and repeats the last pair on underrun.
module i2s_tx #(
   parameter int unsigned BIT_WIDTH = 24,
   parameter int unsigned SLOT_BITS = 32,
   parameter int unsigned BCLK_DIV  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BIT_WIDTH-1:0] l_data,
   input  logic [BIT_WIDTH-1:0] r_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 bclk,
   output logic                 lrclk,
   output logic                 sdata,
   output logic                 underrun
);

   localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
   localparam int unsigned BC_W       = $clog2(FRAME_BITS);
   localparam int unsigned DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
   localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(FRAME_BITS - 1);
   localparam logic [BC_W-1:0]  SLOT     = BC_W'(SLOT_BITS);

   logic [DIV_W-1:0]     div_cnt;
   logic [BC_W-1:0]      bit_cnt;
   logic [BC_W-1:0]      bc_next;
   logic [BC_W-1:0]      pos;
   logic                 div_wrap;
   logic                 fall_evt;
   logic                 frame_load;
   logic                 lr_next;
   logic                 bit_next;
   logic                 hold_full;
   logic [BIT_WIDTH-1:0] hold_l;
   logic [BIT_WIDTH-1:0] hold_r;
   logic [BIT_WIDTH-1:0] frame_l;
   logic [BIT_WIDTH-1:0] frame_r;
   logic [BIT_WIDTH-1:0] sample;
   logic [BIT_WIDTH:0]   shifted;

   assign in_ready   = ~hold_full;
   assign div_wrap   = (div_cnt == DIV_LAST);
   assign fall_evt   = div_wrap & bclk;
   assign bc_next    = (bit_cnt == BC_LAST) ? '0 : bit_cnt + 1'b1;
   assign frame_load = fall_evt & (bc_next == '0);
   assign lr_next    = (bc_next >= SLOT);
   assign pos        = lr_next ? bc_next - SLOT : bc_next;
   assign sample     = lr_next ? frame_r : frame_l;

   // Shifting {0,sample} left by the slot position puts sample[BIT_WIDTH-p] on the
   // top bit; p=0 yields the leading 0 delay bit and p>BIT_WIDTH shifts in 0 padding.
   always_comb begin
      shifted  = {1'b0, sample} << pos;
      bit_next = shifted[BIT_WIDTH];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else if (div_wrap) begin
         div_cnt <= '0;
         bclk    <= ~bclk;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt <= BC_LAST;
         lrclk   <= 1'b0;
         sdata   <= 1'b0;
      end else if (fall_evt) begin
         bit_cnt <= bc_next;
         lrclk   <= lr_next;
         sdata   <= bit_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_l  <= '0;
         frame_r  <= '0;
         underrun <= 1'b0;
      end else begin
         underrun <= frame_load & ~hold_full;
         if (frame_load && hold_full) begin
            frame_l <= hold_l;
            frame_r <= hold_r;
         end
      end
   end

   // A load takes priority; a capture on a load edge with holding empty lands for the next frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_l    <= '0;
         hold_r    <= '0;
         hold_full <= 1'b0;
      end else if (frame_load && hold_full) begin
         hold_full <= 1'b0;
      end else if (in_valid && !hold_full) begin
         hold_l    <= l_data;
         hold_r    <= r_data;
         hold_full <= 1'b1;
      end
   end

endmodule
